// File: rtl/i2c_target_responder.sv
// i2c_target_responder
//   I2C target (slave) answering a single 7-bit address on one bus.
//   Decodes START, repeated START and STOP. Bytes written by the master
//   come out on a push strobe. Bytes read by the master are taken from a
//   valid/ready source.
//
//   Optional feature macro: I2C_TARGET_CLK_STRETCH_EN
//     defined   - an empty read source stretches SCL until data arrives.
//     undefined - scl_o is tied high; an empty source sends 8'hFF and sets
//                 the sticky underflow_o flag.
//
// Ports
//   clk_i, rst_i            clock, asynchronous active-high reset
//   scl_i, sda_i            raw bus line levels (asynchronous)
//   scl_o, sda_o            open-drain controls (0 = pull low, 1 = release)
//   wr_data_o, wr_valid_o   written byte and its 1-cycle strobe
//   wr_full_i               sink full: the byte is NACKed and dropped
//   rd_data_i, rd_valid_i   next byte to return to the master
//   rd_ready_o              1-cycle strobe: rd_data_i consumed
//   busy_o                  addressed transaction in progress
//   underflow_o             sticky: a read byte was needed but unavailable
`timescale 1ns/1ps
module i2c_target_responder #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h22,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_o,
  output logic       sda_o,
  output logic [7:0] wr_data_o,
  output logic       wr_valid_o,
  input  logic       wr_full_i,
  input  logic [7:0] rd_data_i,
  input  logic       rd_valid_i,
  output logic       rd_ready_o,
  output logic       busy_o,
  output logic       underflow_o
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] ADDR     = 3'd1;
  localparam logic [2:0] ADDR_ACK = 3'd2;
  localparam logic [2:0] WR_BYTE  = 3'd3;
  localparam logic [2:0] WR_ACK   = 3'd4;
  localparam logic [2:0] RD_BYTE  = 3'd5;
  localparam logic [2:0] RD_ACK   = 3'd6;
  localparam logic [2:0] IGNORE   = 3'd7;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic       scl_s, sda_s, scl_d, sda_d;
  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [2:0] state;
  logic [3:0] bit_cnt;
  logic [7:0] shreg;
  logic [7:0] new_byte;
  logic       rw;       // R/W bit of the decoded address
  logic       phase;    // set once the 9th (ACK) rising edge has been seen
  logic       pushed;   // current write byte was accepted by the sink
  logic       push;
  logic       fetch;

`ifdef I2C_TARGET_CLK_STRETCH_EN
  logic scl_hold;
  logic stretch;
  assign scl_o       = scl_hold;
  assign underflow_o = 1'b0;
`else
  logic underflow_r;
  assign scl_o       = 1'b1;
  assign underflow_o = underflow_r;
`endif

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & sda_d & ~sda_s;
  assign stop_det  = scl_s & ~sda_d & sda_s;
  assign new_byte  = {shreg[6:0], sda_s};
  // The push is decided independently of START/STOP so a byte completed
  // in the same cycle as a bus condition is still delivered.
  assign push  = (state == WR_BYTE) & scl_rise & (bit_cnt == 4'd7) & ~wr_full_i;
  // Falling edge that closes an ACK and begins a read byte.
  assign fetch = scl_fall & phase &
                 (((state == ADDR_ACK) & rw) | (state == RD_ACK));

  // Line synchronizers plus one-cycle delayed copies for edge detection.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  // Protocol state machine, shift register and all registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      bit_cnt    <= 4'd0;
      shreg      <= 8'd0;
      rw         <= 1'b0;
      phase      <= 1'b0;
      pushed     <= 1'b0;
      sda_o      <= 1'b1;
      wr_data_o  <= 8'd0;
      wr_valid_o <= 1'b0;
      rd_ready_o <= 1'b0;
      busy_o     <= 1'b0;
`ifdef I2C_TARGET_CLK_STRETCH_EN
      scl_hold   <= 1'b1;
      stretch    <= 1'b0;
`else
      underflow_r <= 1'b0;
`endif
    end else begin
      wr_valid_o <= push;
      rd_ready_o <= 1'b0;
      if (push) begin
        wr_data_o <= new_byte;
      end
      if (start_det) begin
        state   <= ADDR;
        bit_cnt <= 4'd0;
        phase   <= 1'b0;
        sda_o   <= 1'b1;
`ifdef I2C_TARGET_CLK_STRETCH_EN
        scl_hold <= 1'b1;
        stretch  <= 1'b0;
`endif
      end else if (stop_det) begin
        state  <= IDLE;
        busy_o <= 1'b0;
        sda_o  <= 1'b1;
`ifdef I2C_TARGET_CLK_STRETCH_EN
        scl_hold <= 1'b1;
        stretch  <= 1'b0;
`endif
`ifdef I2C_TARGET_CLK_STRETCH_EN
      end else if (stretch) begin
        // SCL is held low; wait for the source, then load and let go.
        if (rd_valid_i) begin
          stretch    <= 1'b0;
          scl_hold   <= 1'b1;
          rd_ready_o <= 1'b1;
          shreg      <= rd_data_i;
          sda_o      <= rd_data_i[7];
        end
`endif
      end else begin
        case (state)
          IDLE, IGNORE: begin
          end
          ADDR: begin
            if (scl_rise) begin
              shreg   <= new_byte;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                if (new_byte[7:1] == SLAVE_ADDR) begin
                  state  <= ADDR_ACK;
                  busy_o <= 1'b1;
                  rw     <= new_byte[0];
                  phase  <= 1'b0;
                end else begin
                  state  <= IGNORE;
                  busy_o <= 1'b0;
                end
              end
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              if (!phase) begin
                sda_o <= 1'b0;
              end else begin
                sda_o   <= 1'b1;
                bit_cnt <= 4'd0;
                state   <= rw ? RD_BYTE : WR_BYTE;
              end
            end else if (scl_rise) begin
              phase <= 1'b1;
            end
          end
          WR_BYTE: begin
            if (scl_rise) begin
              shreg   <= new_byte;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                pushed <= ~wr_full_i;
                state  <= WR_ACK;
                phase  <= 1'b0;
              end
            end
          end
          WR_ACK: begin
            if (scl_fall) begin
              if (!phase) begin
                sda_o <= ~pushed;   // ACK only if the sink took the byte
              end else begin
                sda_o   <= 1'b1;
                bit_cnt <= 4'd0;
                state   <= WR_BYTE;
              end
            end else if (scl_rise) begin
              phase <= 1'b1;
            end
          end
          RD_BYTE: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                state <= RD_ACK;
                sda_o <= 1'b1;
                phase <= 1'b0;
              end else begin
                shreg <= {shreg[6:0], 1'b0};
                sda_o <= shreg[6];
              end
            end
          end
          RD_ACK: begin
            if (scl_rise) begin
              if (sda_s) begin
                state <= IGNORE;   // master NACK ends the read
              end else begin
                phase <= 1'b1;
              end
            end else if (scl_fall && phase) begin
              state <= RD_BYTE;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
        // Load the next read byte; overrides the ACK release above.
        if (fetch) begin
          bit_cnt <= 4'd0;
          if (rd_valid_i) begin
            rd_ready_o <= 1'b1;
            shreg      <= rd_data_i;
            sda_o      <= rd_data_i[7];
          end else begin
            sda_o <= 1'b1;
`ifdef I2C_TARGET_CLK_STRETCH_EN
            stretch  <= 1'b1;
            scl_hold <= 1'b0;
`else
            shreg       <= 8'hFF;
            underflow_r <= 1'b1;
`endif
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_responder.sv
// Directed bench for i2c_target_responder: a bit-banged I2C master drives
// the bus through open-drain wired-AND with the target's line controls.
`timescale 1ns/1ps
module tb_i2c_target_responder;

  localparam int Q = 8;   // quarter SCL period in system clocks

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       scl_m, sda_m;
  logic       scl_i, sda_i;
  logic       scl_o, sda_o;
  logic [7:0] wr_data_o;
  logic       wr_valid_o;
  logic       wr_full_i;
  logic [7:0] rd_data_i;
  logic       rd_valid_i;
  logic       rd_ready_o;
  logic       busy_o;
  logic       underflow_o;

  int total = 0;
  int bad   = 0;
  int wr_cnt = 0;
  int rd_ptr = 0;
  int rd_wr  = 0;
  int sda_low_cnt = 0;
  logic [7:0] wr_log [0:15];
  logic [7:0] rd_mem [0:15];

  always #5 clk_i = ~clk_i;

  assign scl_i      = scl_m & scl_o;
  assign sda_i      = sda_m & sda_o;
  assign rd_valid_i = (rd_ptr != rd_wr);
  assign rd_data_i  = rd_mem[rd_ptr[3:0]];

  i2c_target_responder #(.SLAVE_ADDR(7'h22), .SYNC_STAGES(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .scl_i(scl_i), .sda_i(sda_i),
    .scl_o(scl_o), .sda_o(sda_o), .wr_data_o(wr_data_o),
    .wr_valid_o(wr_valid_o), .wr_full_i(wr_full_i), .rd_data_i(rd_data_i),
    .rd_valid_i(rd_valid_i), .rd_ready_o(rd_ready_o), .busy_o(busy_o),
    .underflow_o(underflow_o)
  );

  // Sink log, read-source pointer and SDA-low activity counter.
  always @(negedge clk_i) begin
    if (wr_valid_o) begin
      wr_log[wr_cnt[3:0]] <= wr_data_o;
      wr_cnt <= wr_cnt + 1;
    end
    if (rd_ready_o) rd_ptr <= rd_ptr + 1;
    if (sda_o === 1'b0) sda_low_cnt <= sda_low_cnt + 1;
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  // One SCL period; returns the SDA level seen mid-high.
  task automatic bit_xfer(input logic b, output logic seen);
    int k;
    wait_n(Q); sda_m = b;
    wait_n(Q); scl_m = 1'b1;
    k = 0;
    while (scl_i !== 1'b1 && k < 400) begin
      @(negedge clk_i); k++;
    end
    if (scl_i !== 1'b1) begin
      total++; bad++;
      $display("FAIL scl_release_timeout: scl_i=%b required 1", scl_i);
    end
    wait_n(Q); seen = sda_i;
    wait_n(Q); scl_m = 1'b0;
  endtask

  task automatic start_cond;
    sda_m = 1'b0; wait_n(Q); scl_m = 1'b0;
  endtask

  task automatic rep_start;
    wait_n(Q); sda_m = 1'b1; wait_n(Q); scl_m = 1'b1;
    wait_n(Q); sda_m = 1'b0; wait_n(Q); scl_m = 1'b0;
  endtask

  task automatic stop_cond;
    wait_n(Q); sda_m = 1'b0; wait_n(Q); scl_m = 1'b1;
    wait_n(Q); sda_m = 1'b1; wait_n(2*Q);
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_xfer(d[i], s);
    bit_xfer(1'b1, ack);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    logic s;
    d = 8'd0;
    for (int i = 0; i < 8; i++) begin
      bit_xfer(1'b1, s);
      d = {d[6:0], s};
    end
    bit_xfer(mack, s);
  endtask

  task automatic test_reset;
    rst_i = 1'b1; wait_n(3);
    total++; if (sda_o !== 1'b1) begin bad++; $display("FAIL rst_sda: got %b want 1", sda_o); end
    total++; if (scl_o !== 1'b1) begin bad++; $display("FAIL rst_scl: got %b want 1", scl_o); end
    total++; if (wr_data_o !== 8'h00) begin bad++; $display("FAIL rst_wr_data: got %h want 00", wr_data_o); end
    total++; if ({wr_valid_o, rd_ready_o} !== 2'b00) begin bad++; $display("FAIL rst_strobes: got %b want 00", {wr_valid_o, rd_ready_o}); end
    total++; if ({busy_o, underflow_o} !== 2'b00) begin bad++; $display("FAIL rst_flags: got %b want 00", {busy_o, underflow_o}); end
    rst_i = 1'b0; wait_n(5);
  endtask

  task automatic test_write;
    logic a; int w0;
    w0 = wr_cnt;
    start_cond;
    send_byte(8'h44, a);
    total++; if (a !== 1'b0) begin bad++; $display("FAIL t1_addr_ack: got %b want 0", a); end
    total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL t1_busy: got %b want 1", busy_o); end
    send_byte(8'hA5, a);
    total++; if (a !== 1'b0) begin bad++; $display("FAIL t1_ack_a5: got %b want 0", a); end
    send_byte(8'h3C, a);
    total++; if (a !== 1'b0) begin bad++; $display("FAIL t1_ack_3c: got %b want 0", a); end
    stop_cond;
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL t1_busy_stop: got %b want 0", busy_o); end
    total++; if (wr_cnt != w0 + 2) begin bad++; $display("FAIL t1_wr_count: got %0d want %0d", wr_cnt - w0, 2); end
    total++; if (wr_log[w0] !== 8'hA5) begin bad++; $display("FAIL t1_byte0: got %h want a5", wr_log[w0]); end
    total++; if (wr_log[w0+1] !== 8'h3C) begin bad++; $display("FAIL t1_byte1: got %h want 3c", wr_log[w0+1]); end
  endtask

  task automatic test_addr_mismatch;
    logic a; int w0; int l0;
    w0 = wr_cnt; l0 = sda_low_cnt;
    start_cond;
    send_byte(8'h46, a);
    total++; if (a !== 1'b1) begin bad++; $display("FAIL t2_addr_nack: got %b want 1", a); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL t2_busy: got %b want 0", busy_o); end
    send_byte(8'h55, a);
    total++; if (a !== 1'b1) begin bad++; $display("FAIL t2_data_nack: got %b want 1", a); end
    stop_cond;
    total++; if (sda_low_cnt != l0) begin bad++; $display("FAIL t2_sda_quiet: got %0d low cycles want 0", sda_low_cnt - l0); end
    total++; if (wr_cnt != w0) begin bad++; $display("FAIL t2_no_push: got %0d want 0", wr_cnt - w0); end
    start_cond;
    send_byte(8'h44, a);
    total++; if (a !== 1'b0) begin bad++; $display("FAIL t2_next_ack: got %b want 0", a); end
    stop_cond;
  endtask

  task automatic test_read;
    logic a; logic [7:0] d; int r0;
    rd_mem[rd_wr] = 8'h5A; rd_mem[rd_wr+1] = 8'hC3; rd_wr = rd_wr + 2;
    r0 = rd_ptr;
    start_cond;
    send_byte(8'h45, a);
    total++; if (a !== 1'b0) begin bad++; $display("FAIL t3_addr_ack: got %b want 0", a); end
    read_byte(1'b0, d);
    total++; if (d !== 8'h5A) begin bad++; $display("FAIL t3_byte0: got %h want 5a", d); end
    read_byte(1'b1, d);
    total++; if (d !== 8'hC3) begin bad++; $display("FAIL t3_byte1: got %h want c3", d); end
    wait_n(Q);
    total++; if (sda_o !== 1'b1) begin bad++; $display("FAIL t3_release: got %b want 1", sda_o); end
    total++; if (rd_ptr != r0 + 2) begin bad++; $display("FAIL t3_rd_count: got %0d want 2", rd_ptr - r0); end
    stop_cond;
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL t3_busy_stop: got %b want 0", busy_o); end
  endtask

  task automatic test_full_rep_start;
    logic a; logic [7:0] d; int w0;
    w0 = wr_cnt;
    wr_full_i = 1'b1;
    start_cond;
    send_byte(8'h44, a);
    total++; if (a !== 1'b0) begin bad++; $display("FAIL t4_addr_ack: got %b want 0", a); end
    send_byte(8'h11, a);
    total++; if (a !== 1'b1) begin bad++; $display("FAIL t4_full_nack: got %b want 1", a); end
    total++; if (wr_cnt != w0) begin bad++; $display("FAIL t4_no_push: got %0d want 0", wr_cnt - w0); end
    wr_full_i = 1'b0;
    rd_mem[rd_wr] = 8'h96; rd_wr = rd_wr + 1;
    rep_start;
    total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL t4_busy_rs: got %b want 1", busy_o); end
    send_byte(8'h45, a);
    total++; if (a !== 1'b0) begin bad++; $display("FAIL t4_rs_ack: got %b want 0", a); end
    read_byte(1'b1, d);
    total++; if (d !== 8'h96) begin bad++; $display("FAIL t4_rd_byte: got %h want 96", d); end
    stop_cond;
  endtask

  task automatic test_underflow;
    logic a; logic [7:0] d; int r0;
    r0 = rd_ptr;
    total++; if (underflow_o !== 1'b0) begin bad++; $display("FAIL t5_uf_before: got %b want 0", underflow_o); end
    start_cond;
    send_byte(8'h45, a);
    total++; if (a !== 1'b0) begin bad++; $display("FAIL t5_addr_ack: got %b want 0", a); end
`ifdef I2C_TARGET_CLK_STRETCH_EN
    wait_n(20);
    total++; if (scl_o !== 1'b0) begin bad++; $display("FAIL t5_stretch: got %b want 0", scl_o); end
    total++; if (rd_ptr != r0) begin bad++; $display("FAIL t5_no_consume: got %0d want 0", rd_ptr - r0); end
    wait_n(30);
    rd_mem[rd_wr] = 8'h7E; rd_wr = rd_wr + 1;
    read_byte(1'b1, d);
    total++; if (d !== 8'h7E) begin bad++; $display("FAIL t5_byte: got %h want 7e", d); end
    total++; if (rd_ptr != r0 + 1) begin bad++; $display("FAIL t5_rd_count: got %0d want 1", rd_ptr - r0); end
    total++; if (underflow_o !== 1'b0) begin bad++; $display("FAIL t5_uf: got %b want 0", underflow_o); end
`else
    wait_n(50);
    read_byte(1'b1, d);
    total++; if (d !== 8'hFF) begin bad++; $display("FAIL t5_byte: got %h want ff", d); end
    total++; if (underflow_o !== 1'b1) begin bad++; $display("FAIL t5_uf: got %b want 1", underflow_o); end
    total++; if (rd_ptr != r0) begin bad++; $display("FAIL t5_no_consume: got %0d want 0", rd_ptr - r0); end
`endif
    stop_cond;
  endtask

  task automatic test_reset_mid_ack;
    logic s; logic a;
    logic [7:0] addr;
    addr = 8'h44;
    start_cond;
    for (int i = 7; i >= 0; i--) bit_xfer(addr[i], s);
    wait_n(6);
    total++; if (sda_o !== 1'b0) begin bad++; $display("FAIL t6_ack_low: got %b want 0", sda_o); end
    rst_i = 1'b1;
    #1;
    total++; if (sda_o !== 1'b1) begin bad++; $display("FAIL t6_sda_rel: got %b want 1", sda_o); end
    total++; if (scl_o !== 1'b1) begin bad++; $display("FAIL t6_scl_rel: got %b want 1", scl_o); end
    total++; if ({wr_valid_o, rd_ready_o, busy_o, underflow_o} !== 4'b0000) begin
      bad++; $display("FAIL t6_flags: got %b want 0000", {wr_valid_o, rd_ready_o, busy_o, underflow_o});
    end
    wait_n(2);
    rst_i = 1'b0;
    sda_m = 1'b1; scl_m = 1'b1;
    wait_n(10);
    start_cond;
    send_byte(8'h44, a);
    total++; if (a !== 1'b0) begin bad++; $display("FAIL t6_after_ack: got %b want 0", a); end
    stop_cond;
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL t6_busy_end: got %b want 0", busy_o); end
  endtask

  initial begin
    scl_m = 1'b1; sda_m = 1'b1; wr_full_i = 1'b0; rst_i = 1'b1;
    for (int i = 0; i < 16; i++) rd_mem[i] = 8'h00;
    test_reset;
    test_write;
    test_addr_mismatch;
    test_read;
    test_full_rep_start;
    test_underflow;
    test_reset_mid_ack;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
